mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised N-port memory arbiter between multiple LC-3b-style requesters and one shared memory port. Typical requesters are the instruction-fetch and data paths of the multicycle CPU, or the I-cache and D-cache.
- Upstream and downstream both use the read/write + resp handshake. Generalised in port count, data/address width and byte-mask width.
- Round-robin fairness and a watchdog timeout.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- DATA_WIDTH, 16, data bus width (multiple of 8).
- ADDR_WIDTH, 16, address width.
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width.
- TIMEOUT_CYCLES, 0, max cycles waiting for mem_resp; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_read  in  NUM_PORTS  per-port read request
- req_write  in  NUM_PORTS  per-port write request
- req_address  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data
- req_byte_enable  in  NUM_PORTS*MASK_WIDTH  packed byte masks
- req_resp  out  NUM_PORTS  per-port completion pulse
- req_rdata  out  DATA_WIDTH  shared read data, valid with req_resp
- req_err  out  1  with req_resp: transaction aborted by timeout
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_byte_enable  out  MASK_WIDTH  downstream byte mask
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data
- grant  out  $clog2(NUM_PORTS) (min 1)  index of current/last granted port
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any state):
  - State = IDLE; all outputs 0 (grant = 0, timeout_err = 0).
  - last_grant = NUM_PORTS-1, so port 0 wins first.
  - Any transaction in flight is abandoned with no resp.
- Upstream contract: a requester holds read/write, address, wdata and mask stable until its req_resp. It drops the request in the cycle after req_resp.
- Read and write both high on one port = write; read is ignored.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - A port is requesting if read|write is high.
  - Winner = first requesting port scanning last_grant+1, +2, ... modulo NUM_PORTS.
  - On a winner: latch its address, wdata, mask and op into output registers; set grant and last_grant; go to BUSY.
  - mem_read/mem_write become high the next cycle (1-cycle arbitration latency).
  - No request: stay in IDLE.
- BUSY:
  - mem_read or mem_write is held high (registered, glitch-free); address, wdata and mask are stable.
  - On mem_resp: req_resp[grant] is high in the same cycle (combinational from mem_resp, gated by BUSY); req_rdata = mem_rdata, req_err = 0. Next state = RELEASE.
  - mem_read/mem_write are low from the next edge.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_resp.
  - When count == TIMEOUT_CYCLES-1 and no mem_resp: pulse req_resp[grant] with req_err = 1, req_rdata = 0; set timeout_err (sticky until reset); go to RELEASE.
  - mem_resp and timeout in the same cycle: mem_resp wins, no error.
- RELEASE:
  - Exactly one cycle; no mem strobes. Lets the finished requester deassert.
  - Then IDLE. Back-to-back gap: mem_resp cycle k, next mem strobe at k+3.
- req_resp and req_rdata are 0 outside a completing BUSY cycle.
- mem_resp seen in IDLE or RELEASE is ignored.
- Fairness: with all ports continuously requesting, grants rotate 0,1,...,N-1,0. No port waits more than N-1 transactions.
- Requests that drop before being granted are simply not selected; there is no queueing.

Test Plan:
- Single read, port 0, address 0x1234, memory responds 2 cycles after strobe with 0xBEEF → mem_read high 1 cycle after request, mem_address = 0x1234; req_resp[0] pulses 1 cycle with req_rdata = 0xBEEF; mem_read low next cycle.
- Write, port 1, address 0x0040, wdata 0xA55A, mask 2'b01 → mem_write = 1, mem_wdata = 0xA55A, mem_byte_enable = 01; req_resp[1] only; req_resp[0] stays 0.
- Both ports request continuously for 6 transactions (NUM_PORTS = 2) → grant sequence 0,1,0,1,0,1; 2-cycle gap (RELEASE, IDLE) between mem_resp and the next strobe.
- TIMEOUT_CYCLES = 8, memory never responds → req_resp pulses with req_err = 1 exactly 8 BUSY cycles after strobe; timeout_err sticks at 1; next request is served normally.
- reset_n asserted mid-BUSY → mem_read/mem_write/req_resp drop to 0 immediately (async); after release, port 0 wins the first arbitration.
- NUM_PORTS = 4, DATA_WIDTH = 32, ports 2 and 3 request with last_grant = 2 → port 3 wins, then port 2; 32-bit data and 4-bit masks pass through unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus bundle for mem_arbiter
//   master: requesters and memory drive req_read/req_write/req_address/req_wdata/req_byte_enable, mem_resp, mem_rdata
//   slave : arbiter drives req_resp/req_rdata/req_err and the mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable strobes
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*MASK_WIDTH-1:0] req_byte_enable;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic                            req_err;
  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [MASK_WIDTH-1:0]           mem_byte_enable;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  modport master (
    output req_read, req_write, req_address, req_wdata, req_byte_enable, mem_resp, mem_rdata,
    input  req_resp, req_rdata, req_err, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
  modport slave (
    input  req_read, req_write, req_address, req_wdata, req_byte_enable, mem_resp, mem_rdata,
    output req_resp, req_rdata, req_err, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port arbiter onto one shared memory port with optional watchdog
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : per-port read/write requests in, shared registered mem_* strobes out
//   grant        : index of the current/last granted port
//   timeout_err  : sticky flag set when the watchdog aborts a transaction
module mem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int GW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus,
  output logic [GW-1:0] grant,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t               state, state_n;
  logic [GW-1:0]        last_grant, win;
  logic [NUM_PORTS-1:0] req, one_hot;
  logic                 found, busy, hit, done;
  logic [31:0]          cnt;
  assign req = bus.req_read | bus.req_write;
  // scan downward so the port nearest after last_grant overwrites farther ones
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NUM_PORTS; k >= 1; k--)
      if (req[(int'(last_grant) + k) % NUM_PORTS]) begin
        found = 1'b1;
        win = GW'((int'(last_grant) + k) % NUM_PORTS);
      end
  end
  assign busy = state == BUSY;
  // a real response in the deadline cycle beats the watchdog
  assign hit = TIMEOUT_CYCLES > 0 && cnt == 32'(TIMEOUT_CYCLES - 1) && !bus.mem_resp;
  assign done = busy && (bus.mem_resp || hit);
  assign one_hot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant;
  assign bus.req_resp = done ? one_hot : '0;
  assign bus.req_rdata = busy && bus.mem_resp ? bus.mem_rdata : '0;
  assign bus.req_err = busy && hit;
  always_comb state_n = state == IDLE ? (found ? BUSY : IDLE) : state == BUSY ? (done ? RELEASE : BUSY) : IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      cnt <= '0;
      timeout_err <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata <= '0;
      bus.mem_byte_enable <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        grant <= win;
        last_grant <= win;
        cnt <= '0;
        bus.mem_write <= bus.req_write[win];
        bus.mem_read <= !bus.req_write[win];
        bus.mem_address <= bus.req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata <= bus.req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        bus.mem_byte_enable <= bus.req_byte_enable[int'(win)*MASK_WIDTH +: MASK_WIDTH];
      end else if (done) begin
        bus.mem_read <= 1'b0;
        bus.mem_write <= 1'b0;
      end else if (busy)
        cnt <= cnt + 32'd1;
      if (bus.req_err)
        timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and randomized round-robin model check for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_arbiter_if #(.NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16)) bus_a();
  mem_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16)) bus_b();
  logic       grant_a, terr_a, terr_b;
  logic [1:0] grant_b;
  mem_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .grant(grant_a), .timeout_err(terr_a));
  mem_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .grant(grant_b), .timeout_err(terr_b));

  typedef struct {
    int port; logic rd, wr; logic [15:0] addr, wdata; logic [1:0] mask; int lat; logic [15:0] mdata;
    logic exp_rd, exp_wr; logic [1:0] exp_resp; logic [15:0] exp_rdata; logic exp_err; int exp_busy; logic exp_terr;
  } vec_t;
  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs;
    bus_a.req_read = '0; bus_a.req_write = '0; bus_a.req_address = '0; bus_a.req_wdata = '0;
    bus_a.req_byte_enable = '0; bus_a.mem_resp = 1'b0; bus_a.mem_rdata = '0;
    bus_b.req_read = '0; bus_b.req_write = '0; bus_b.req_address = '0; bus_b.req_wdata = '0;
    bus_b.req_byte_enable = '0; bus_b.mem_resp = 1'b0; bus_b.mem_rdata = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n;
    logic got;
    @(negedge clk);
    bus_a.req_read[v.port] = v.rd;
    bus_a.req_write[v.port] = v.wr;
    bus_a.req_address[v.port*16 +: 16] = v.addr;
    bus_a.req_wdata[v.port*16 +: 16] = v.wdata;
    bus_a.req_byte_enable[v.port*2 +: 2] = v.mask;
    got = 1'b0;
    for (n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      bus_a.mem_resp = (n == v.lat);
      bus_a.mem_rdata = v.mdata;
      #1;
      if (n == 0) begin
        chk($sformatf("vec%0d_mem_read", i), bus_a.mem_read, v.exp_rd);
        chk($sformatf("vec%0d_mem_write", i), bus_a.mem_write, v.exp_wr);
        chk($sformatf("vec%0d_addr", i), bus_a.mem_address, v.addr);
        chk($sformatf("vec%0d_wdata", i), bus_a.mem_wdata, v.wdata);
        chk($sformatf("vec%0d_mask", i), bus_a.mem_byte_enable, v.mask);
        chk($sformatf("vec%0d_grant", i), grant_a, v.port);
      end
      got = bus_a.req_resp != 0;
    end
    chk($sformatf("vec%0d_busy_cycles", i), n, v.exp_busy);
    chk($sformatf("vec%0d_resp", i), bus_a.req_resp, v.exp_resp);
    chk($sformatf("vec%0d_rdata", i), bus_a.req_rdata, v.exp_rdata);
    chk($sformatf("vec%0d_err", i), bus_a.req_err, v.exp_err);
    @(negedge clk);
    bus_a.mem_resp = 1'b1;
    bus_a.req_read = '0;
    bus_a.req_write = '0;
    #1;
    chk($sformatf("vec%0d_release_strobes", i), {bus_a.mem_read, bus_a.mem_write}, 2'b00);
    chk($sformatf("vec%0d_release_resp", i), {bus_a.req_resp, bus_a.req_rdata}, 0);
    chk($sformatf("vec%0d_timeout_err", i), terr_a, v.exp_terr);
    @(negedge clk);
    bus_a.mem_resp = 1'b0;
  endtask

  logic [3:0]  act, pend;
  logic        r_wr [4];
  logic [15:0] r_addr [4];
  logic [31:0] r_wd [4];
  logic [3:0]  r_mk [4];

  initial begin
    int w, resp_cyc, e, mlast, lat, done_cnt;
    int unsigned rw;
    logic in_txn;
    vecs[0] = '{0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11, 2,  16'hBEEF, 1'b1, 1'b0, 2'b01, 16'hBEEF, 1'b0, 3, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h0040, 16'hA55A, 2'b01, 1,  16'h1111, 1'b0, 1'b1, 2'b10, 16'h1111, 1'b0, 2, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b1, 16'h0F0F, 16'h1357, 2'b11, 0,  16'h2222, 1'b0, 1'b1, 2'b01, 16'h2222, 1'b0, 1, 1'b0};
    vecs[3] = '{1, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b11, 7,  16'hCAFE, 1'b1, 1'b0, 2'b10, 16'hCAFE, 1'b0, 8, 1'b0};
    vecs[4] = '{0, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b11, 99, 16'hFFFF, 1'b1, 1'b0, 2'b01, 16'h0000, 1'b1, 8, 1'b1};
    vecs[5] = '{1, 1'b1, 1'b0, 16'h8000, 16'h0000, 2'b11, 0,  16'h0BAD, 1'b1, 1'b0, 2'b10, 16'h0BAD, 1'b0, 1, 1'b1};
    vecs[6] = '{1, 1'b0, 1'b1, 16'h0444, 16'h5A5A, 2'b10, 99, 16'hFFFF, 1'b0, 1'b1, 2'b10, 16'h0000, 1'b1, 8, 1'b1};
    clear_inputs();
    #1;
    chk("reset_a_outputs", {bus_a.mem_read, bus_a.mem_write, bus_a.mem_address, bus_a.req_resp, grant_a, terr_a}, 0);
    chk("reset_b_outputs", {bus_b.mem_read, bus_b.mem_write, bus_b.mem_wdata, bus_b.req_resp, grant_b, terr_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // both ports requesting continuously: strict alternation with a 3-cycle resp-to-strobe gap
    @(negedge clk);
    bus_a.req_address = {16'h0101, 16'h0100};
    bus_a.req_read = 2'b11;
    resp_cyc = 0;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      while (!bus_a.mem_read && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("rr_strobe_seen", w < 10, 1'b1);
      chk("rr_grant", grant_a, t % 2);
      chk("rr_addr", bus_a.mem_address, 16'h0100 + t % 2);
      if (t > 0) chk("rr_gap", cyc - resp_cyc, 3);
      @(negedge clk);
      bus_a.mem_resp = 1'b1;
      bus_a.mem_rdata = 16'h7000 + 16'(t);
      #1;
      chk("rr_resp", bus_a.req_resp, 2'b01 << (t % 2));
      chk("rr_rdata", bus_a.req_rdata, 16'h7000 + t);
      resp_cyc = cyc;
      @(negedge clk);
      bus_a.mem_resp = 1'b0;
      bus_a.req_read[t % 2] = 1'b0;
      @(negedge clk);
      bus_a.req_read[t % 2] = 1'b1;
    end
    do_reset();

    for (int i = 0; i <= 6; i++) run_vec(vecs[i], i);

    // asynchronous reset in the middle of a completing BUSY cycle
    @(negedge clk);
    bus_a.req_read[1] = 1'b1;
    bus_a.req_address[16 +: 16] = 16'h0777;
    @(negedge clk);
    bus_a.mem_resp = 1'b1;
    #1;
    chk("midrst_pre_strobe", bus_a.mem_read, 1'b1);
    chk("midrst_pre_resp", bus_a.req_resp, 2'b10);
    chk("midrst_pre_terr", terr_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_strobes", {bus_a.mem_read, bus_a.mem_write}, 2'b00);
    chk("midrst_resp", bus_a.req_resp, 2'b00);
    chk("midrst_grant_terr", {grant_a, terr_a}, 2'b00);
    @(negedge clk);
    bus_a.mem_resp = 1'b0;
    reset_n = 1'b1;
    bus_a.req_read = 2'b11;
    @(negedge clk);
    #1;
    chk("midrst_first_strobe", bus_a.mem_read, 1'b1);
    chk("midrst_first_grant", grant_a, 0);
    do_reset();

    // 4-port, 32-bit: establish last_grant = 2, then ports 2 and 3 contend
    @(negedge clk);
    bus_b.req_write[2] = 1'b1;
    bus_b.req_address[32 +: 16] = 16'h2222;
    bus_b.req_wdata[64 +: 32] = 32'hDEADBEEF;
    bus_b.req_byte_enable[8 +: 4] = 4'b1010;
    @(negedge clk);
    bus_b.mem_resp = 1'b1;
    #1;
    chk("p4_write_strobe", {bus_b.mem_read, bus_b.mem_write}, 2'b01);
    chk("p4_write_grant", grant_b, 2);
    chk("p4_write_data", bus_b.mem_wdata, 32'hDEADBEEF);
    chk("p4_write_mask", bus_b.mem_byte_enable, 4'b1010);
    chk("p4_write_resp", bus_b.req_resp, 4'b0100);
    @(negedge clk);
    bus_b.mem_resp = 1'b0;
    bus_b.req_write = '0;
    @(negedge clk);
    bus_b.req_read = 4'b1100;
    bus_b.req_address = {16'h3333, 16'h3000, 32'h0};
    @(negedge clk);
    bus_b.mem_resp = 1'b1;
    bus_b.mem_rdata = 32'h89ABCDEF;
    #1;
    chk("p4_first_grant", grant_b, 3);
    chk("p4_first_addr", bus_b.mem_address, 16'h3333);
    chk("p4_first_resp", bus_b.req_resp, 4'b1000);
    chk("p4_first_rdata", bus_b.req_rdata, 32'h89ABCDEF);
    @(negedge clk);
    bus_b.mem_resp = 1'b0;
    bus_b.req_read[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("p4_second_grant", grant_b, 2);
    chk("p4_second_addr", bus_b.mem_address, 16'h3000);
    chk("p4_second_strobe", bus_b.mem_read, 1'b1);
    do_reset();

    // randomized traffic against a round-robin reference model
    act = '0; pend = '0; mlast = 3; in_txn = 1'b0; lat = 0; done_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((bus_b.mem_read || bus_b.mem_write) && !in_txn) begin
        e = -1;
        for (int k = 4; k >= 1; k--) if (act[(mlast + k) % 4]) e = (mlast + k) % 4;
        chk("rnd_grant", grant_b, e);
        if (e >= 0) begin
          chk("rnd_addr", bus_b.mem_address, r_addr[e]);
          chk("rnd_op", {bus_b.mem_read, bus_b.mem_write}, {!r_wr[e], r_wr[e]});
          chk("rnd_wdata_mask", {bus_b.mem_wdata, bus_b.mem_byte_enable}, {r_wd[e], r_mk[e]});
          mlast = e;
        end
        in_txn = 1'b1;
        lat = $urandom_range(0, 3);
      end
      bus_b.mem_rdata = $urandom;
      if (in_txn) begin
        bus_b.mem_resp = (lat == 0);
        lat--;
      end else bus_b.mem_resp = ($urandom_range(0, 3) == 0);
      #1;
      for (int p = 0; p < 4; p++)
        if (!act[p] && $urandom_range(0, 2) == 0) begin
          rw = $urandom_range(1, 3);
          act[p] = 1'b1;
          r_wr[p] = rw[1];
          r_addr[p] = 16'($urandom);
          r_wd[p] = $urandom;
          r_mk[p] = 4'($urandom);
          bus_b.req_read[p] = rw[0];
          bus_b.req_write[p] = rw[1];
          bus_b.req_address[p*16 +: 16] = r_addr[p];
          bus_b.req_wdata[p*32 +: 32] = r_wd[p];
          bus_b.req_byte_enable[p*4 +: 4] = r_mk[p];
        end else if (pend[p]) begin
          act[p] = 1'b0;
          pend[p] = 1'b0;
          bus_b.req_read[p] = 1'b0;
          bus_b.req_write[p] = 1'b0;
        end
      if (in_txn && bus_b.mem_resp) begin
        chk("rnd_resp", bus_b.req_resp, 4'b0001 << mlast);
        chk("rnd_rdata", bus_b.req_rdata, bus_b.mem_rdata);
        chk("rnd_err", bus_b.req_err, 1'b0);
        pend[mlast] = 1'b1;
        in_txn = 1'b0;
        done_cnt++;
      end else chk("rnd_quiet", {bus_b.req_resp, bus_b.req_rdata, bus_b.req_err}, 0);
    end
    chk("rnd_progress", done_cnt > 200, 1'b1);
    chk("rnd_no_timeout_flag", terr_b, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
